// File: rtl/mor1kx_wb_latte_pkg.sv
// Shared encodings for the latte writeback stage: result classes, load sizes and FSM states.
package mor1kx_wb_latte_pkg;

    typedef enum logic [1:0] {
        CLASS_ALU  = 2'd0,
        CLASS_LOAD = 2'd1,
        CLASS_MUL  = 2'd2,
        CLASS_NONE = 2'd3
    } wb_class_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } lsu_size_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_LSU = 2'd1,
        ST_WAIT_MUL = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mor1kx_load_ext_latte.sv
// Big-endian load alignment and zero/sign extension; purely combinational.
module mor1kx_load_ext_latte
    import mor1kx_wb_latte_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic [OPTION_OPERAND_WIDTH-1:0] data,
    input  logic [1:0]                      byte_off,
    input  logic [1:0]                      size,
    input  logic                            zext,
    output logic [OPTION_OPERAND_WIDTH-1:0] result
);

    localparam int W = OPTION_OPERAND_WIDTH;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (byte_off)
            2'd0:    byte_sel = data[W-1  -: 8];
            2'd1:    byte_sel = data[W-9  -: 8];
            2'd2:    byte_sel = data[W-17 -: 8];
            default: byte_sel = data[W-25 -: 8];
        endcase
        half_sel = byte_off[1] ? data[W-17 -: 16] : data[W-1 -: 16];

        // Size 3 has no defined meaning and falls through to the word path.
        case (lsu_size_t'(size))
            SIZE_BYTE: result = {{(W-8){~zext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: result = {{(W-16){~zext & half_sel[15]}}, half_sel};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/mor1kx_wb_latte.sv
// Latte writeback stage: waits for the EXECUTE result unit and registers the WB write port.
// Optional load align/extend is enabled by defining MOR1KX_LATTE_WB_LOAD_EXT_EN.
//
// state       | meaning
// ST_IDLE     | no unit outstanding; ALU/NONE and ready units advance at once
// ST_WAIT_LSU | load issued, waiting for lsu_valid_i
// ST_WAIT_MUL | multiply issued, waiting for mul_valid_i
module mor1kx_wb_latte
    import mor1kx_wb_latte_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pipeline_flush_i,
    input  logic                            exec_valid_i,
    input  logic [1:0]                      exec_class_i,
    input  logic                            exec_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] alu_result_i,
    input  logic                            lsu_valid_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i,
    input  logic [1:0]                      lsu_byte_off_i,
    input  logic [1:0]                      lsu_size_i,
    input  logic                            lsu_zext_i,
    input  logic                            mul_valid_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mul_result_i,
    output logic                            exec_busy_o,
    output logic                            padv_wb_o,
    output logic                            wb_new_result_o,
    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o
);

    wb_state_t                       state;
    wb_class_t                       exec_class;
    logic                            padv;
    logic                            class_none;
    logic [OPTION_OPERAND_WIDTH-1:0] load_data;
    logic [OPTION_OPERAND_WIDTH-1:0] result_sel;

`ifdef MOR1KX_LATTE_WB_LOAD_EXT_EN
    mor1kx_load_ext_latte #(
        .OPTION_OPERAND_WIDTH(OPTION_OPERAND_WIDTH)
    ) u_load_ext (
        .data     (lsu_result_i),
        .byte_off (lsu_byte_off_i),
        .size     (lsu_size_i),
        .zext     (lsu_zext_i),
        .result   (load_data)
    );
`else
    // LSU already delivers final data; the alignment controls have no consumer.
    logic unused_load_ctrl;
    assign unused_load_ctrl = ^{lsu_byte_off_i, lsu_size_i, lsu_zext_i};
    assign load_data        = lsu_result_i;
`endif

    always_comb begin
        exec_class = wb_class_t'(exec_class_i);
        padv       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (exec_valid_i) begin
                    unique case (exec_class)
                        CLASS_LOAD: padv = lsu_valid_i;
                        CLASS_MUL:  padv = mul_valid_i;
                        default:    padv = 1'b1;
                    endcase
                end
            end
            ST_WAIT_LSU: padv = lsu_valid_i;
            ST_WAIT_MUL: padv = mul_valid_i;
            default:     padv = 1'b0;
        endcase
        if (pipeline_flush_i)
            padv = 1'b0;

        class_none = (state == ST_IDLE) && (exec_class == CLASS_NONE);

        // In the wait states the class is implied by the state itself.
        if (state == ST_WAIT_LSU || (state == ST_IDLE && exec_class == CLASS_LOAD))
            result_sel = load_data;
        else if (state == ST_WAIT_MUL || (state == ST_IDLE && exec_class == CLASS_MUL))
            result_sel = mul_result_i;
        else
            result_sel = alu_result_i;
    end

    assign padv_wb_o   = padv;
    assign exec_busy_o = exec_valid_i & ~padv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            wb_new_result_o <= 1'b0;
            wb_rf_wb_o      <= 1'b0;
            wb_rfd_adr_o    <= '0;
            wb_result_o     <= '0;
        end else begin
            wb_new_result_o <= padv;
            if (pipeline_flush_i) begin
                state      <= ST_IDLE;
                wb_rf_wb_o <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (exec_valid_i && !padv && exec_class == CLASS_LOAD)
                            state <= ST_WAIT_LSU;
                        else if (exec_valid_i && !padv && exec_class == CLASS_MUL)
                            state <= ST_WAIT_MUL;
                    end
                    ST_WAIT_LSU: if (lsu_valid_i) state <= ST_IDLE;
                    ST_WAIT_MUL: if (mul_valid_i) state <= ST_IDLE;
                    default:     state <= ST_IDLE;
                endcase

                if (padv) begin
                    wb_rfd_adr_o <= exec_rfd_adr_i;
                    wb_rf_wb_o   <= exec_rf_wb_i & ~class_none;
                    if (!class_none)
                        wb_result_o <= result_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_mor1kx_wb_latte.sv
// Directed bench for mor1kx_wb_latte with a commit scoreboard checked on every new-result strobe.
module tb_mor1kx_wb_latte;
    import mor1kx_wb_latte_pkg::*;

`ifdef MOR1KX_LATTE_WB_LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        pipeline_flush_i;
    logic        exec_valid_i;
    logic [1:0]  exec_class_i;
    logic        exec_rf_wb_i;
    logic [4:0]  exec_rfd_adr_i;
    logic [31:0] alu_result_i;
    logic        lsu_valid_i;
    logic [31:0] lsu_result_i;
    logic [1:0]  lsu_byte_off_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_zext_i;
    logic        mul_valid_i;
    logic [31:0] mul_result_i;
    logic        exec_busy_o;
    logic        padv_wb_o;
    logic        wb_new_result_o;
    logic        wb_rf_wb_o;
    logic [4:0]  wb_rfd_adr_o;
    logic [31:0] wb_result_o;

    typedef struct packed {
        logic [4:0]  adr;
        logic        rf_wb;
        logic [31:0] result;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    int   errors = 0;
    int   checks = 0;

    mor1kx_wb_latte dut (
        .clk              (clk),
        .rst              (rst),
        .pipeline_flush_i (pipeline_flush_i),
        .exec_valid_i     (exec_valid_i),
        .exec_class_i     (exec_class_i),
        .exec_rf_wb_i     (exec_rf_wb_i),
        .exec_rfd_adr_i   (exec_rfd_adr_i),
        .alu_result_i     (alu_result_i),
        .lsu_valid_i      (lsu_valid_i),
        .lsu_result_i     (lsu_result_i),
        .lsu_byte_off_i   (lsu_byte_off_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_zext_i       (lsu_zext_i),
        .mul_valid_i      (mul_valid_i),
        .mul_result_i     (mul_result_i),
        .exec_busy_o      (exec_busy_o),
        .padv_wb_o        (padv_wb_o),
        .wb_new_result_o  (wb_new_result_o),
        .wb_rf_wb_o       (wb_rf_wb_o),
        .wb_rfd_adr_o     (wb_rfd_adr_o),
        .wb_result_o      (wb_result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_exec(input logic v, input logic [1:0] c, input logic w, input logic [4:0] a);
        exec_valid_i   = v;
        exec_class_i   = c;
        exec_rf_wb_i   = w;
        exec_rfd_adr_i = a;
    endtask

    task automatic push(input logic [4:0] a, input logic w, input logic [31:0] r);
        exp_t e;
        e.adr    = a;
        e.rf_wb  = w;
        e.result = r;
        sb.push_back(e);
    endtask

    // Single-cycle load (valid arrives with the instruction).
    task automatic do_load(input logic [4:0] rd, input logic [1:0] off, input logic [1:0] sz,
                           input logic zx, input logic [31:0] data, input logic [31:0] ext_exp);
        set_exec(1'b1, CLASS_LOAD, 1'b1, rd);
        lsu_result_i   = data;
        lsu_byte_off_i = off;
        lsu_size_i     = sz;
        lsu_zext_i     = zx;
        lsu_valid_i    = 1'b1;
        #1 chk("load_padv", padv_wb_o, 1);
        push(rd, 1'b1, EXT ? ext_exp : data);
        cyc();
        lsu_valid_i  = 1'b0;
        exec_valid_i = 1'b0;
        #1 chk("load_result", wb_result_o, EXT ? ext_exp : data);
    endtask

    // Every strobe must retire exactly one expected commit.
    always @(negedge clk) begin
        if (!rst && wb_new_result_o) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe: observed=1 expected=0");
            end
            if (sb.size() != 0) begin
                popped = sb.pop_front();
                checks++;
                assert ({wb_rfd_adr_o, wb_rf_wb_o, wb_result_o} === popped) else begin
                    errors++;
                    $error("FAIL wb_commit: observed=%h expected=%h",
                           {wb_rfd_adr_o, wb_rf_wb_o, wb_result_o}, popped);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        pipeline_flush_i = 1'b0;
        set_exec(1'b0, CLASS_ALU, 1'b0, 5'd0);
        alu_result_i = '0; lsu_valid_i = 1'b0; lsu_result_i = '0;
        lsu_byte_off_i = '0; lsu_size_i = SIZE_WORD; lsu_zext_i = 1'b0;
        mul_valid_i = 1'b0; mul_result_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_rf_wb", wb_rf_wb_o, 0);
        chk("rst_new_result", wb_new_result_o, 0);
        chk("rst_adr", wb_rfd_adr_o, 0);
        chk("rst_result", wb_result_o, 0);
        rst = 1'b0;
        cyc();
        chk("idle_busy", exec_busy_o, 0);
        chk("idle_padv", padv_wb_o, 0);

        // ALU single instruction
        set_exec(1'b1, CLASS_ALU, 1'b1, 5'd5);
        alu_result_i = 32'h12345678;
        #1 chk("alu_padv", padv_wb_o, 1);
        chk("alu_busy", exec_busy_o, 0);
        push(5'd5, 1'b1, 32'h12345678);
        cyc();
        exec_valid_i = 1'b0;
        #1 chk("alu_strobe", wb_new_result_o, 1);
        chk("alu_rf_wb", wb_rf_wb_o, 1);
        chk("alu_adr", wb_rfd_adr_o, 5);
        chk("alu_result", wb_result_o, 32'h12345678);
        cyc();
        chk("alu_strobe_once", wb_new_result_o, 0);
        chk("alu_rf_wb_hold", wb_rf_wb_o, 1);

        // Back-to-back ALU instructions
        for (int i = 0; i < 3; i++) begin
            set_exec(1'b1, CLASS_ALU, 1'b1, 5'(10 + i));
            alu_result_i = 32'hA0000000 + 32'(i);
            push(5'(10 + i), 1'b1, 32'hA0000000 + 32'(i));
            cyc();
            if (i > 0) chk("b2b_strobe", wb_new_result_o, 1);
        end
        exec_valid_i = 1'b0;
        cyc();

        // Load whose data arrives three cycles late
        set_exec(1'b1, CLASS_LOAD, 1'b1, 5'd9);
        lsu_result_i = 32'hCAFEF00D; lsu_size_i = SIZE_WORD; lsu_byte_off_i = 2'd0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("ld_wait_busy", exec_busy_o, 1);
            chk("ld_wait_padv", padv_wb_o, 0);
            cyc();
        end
        lsu_valid_i = 1'b1;
        #1 chk("ld_late_padv", padv_wb_o, 1);
        chk("ld_late_busy", exec_busy_o, 0);
        push(5'd9, 1'b1, 32'hCAFEF00D);
        cyc();
        lsu_valid_i = 1'b0; exec_valid_i = 1'b0;
        #1 chk("ld_late_result", wb_result_o, 32'hCAFEF00D);
        cyc();

        // Alignment / extension cases
        do_load(5'd14, 2'd1, SIZE_BYTE, 1'b0, 32'h11F03344, 32'hFFFFFFF0);
        do_load(5'd15, 2'd1, SIZE_BYTE, 1'b1, 32'h11F03344, 32'h000000F0);
        do_load(5'd16, 2'd2, SIZE_HALF, 1'b0, 32'h1234ABCD, 32'hFFFFABCD);
        do_load(5'd17, 2'd3, SIZE_BYTE, 1'b0, 32'hAABBCC85, 32'hFFFFFF85);
        do_load(5'd18, 2'd0, SIZE_HALF, 1'b1, 32'h80017777, 32'h00008001);
        do_load(5'd19, 2'd1, 2'd3,      1'b0, 32'h89ABCDEF, 32'h89ABCDEF);

        // Stray unit pulses with nothing outstanding
        lsu_valid_i = 1'b1; mul_valid_i = 1'b1;
        #1 chk("stray_padv", padv_wb_o, 0);
        cyc();
        lsu_valid_i = 1'b0; mul_valid_i = 1'b0;
        #1 chk("stray_strobe", wb_new_result_o, 0);

        // Multiply completing normally
        set_exec(1'b1, CLASS_MUL, 1'b1, 5'd3);
        #1 chk("mul_busy", exec_busy_o, 1);
        cyc(); cyc();
        mul_valid_i = 1'b1; mul_result_i = 32'h0BADBEEF;
        #1 chk("mul_padv", padv_wb_o, 1);
        push(5'd3, 1'b1, 32'h0BADBEEF);
        cyc();
        mul_valid_i = 1'b0; exec_valid_i = 1'b0;
        #1 chk("mul_result", wb_result_o, 32'h0BADBEEF);

        // Flush while waiting on the multiplier, with its valid in the flush cycle
        set_exec(1'b1, CLASS_MUL, 1'b1, 5'd6);
        cyc(); cyc();
        pipeline_flush_i = 1'b1; mul_valid_i = 1'b1; mul_result_i = 32'hDEADDEAD;
        #1 chk("flush_padv", padv_wb_o, 0);
        cyc();
        pipeline_flush_i = 1'b0; mul_valid_i = 1'b0; exec_valid_i = 1'b0;
        #1 chk("flush_rf_wb", wb_rf_wb_o, 0);
        chk("flush_strobe", wb_new_result_o, 0);
        chk("flush_result_hold", wb_result_o, 32'h0BADBEEF);
        chk("flush_adr_hold", wb_rfd_adr_o, 3);
        set_exec(1'b1, CLASS_ALU, 1'b1, 5'd8);
        alu_result_i = 32'h000000AA;
        #1 chk("post_flush_idle_padv", padv_wb_o, 1);
        push(5'd8, 1'b1, 32'h000000AA);
        cyc();

        // Flush of an ALU instruction in IDLE
        set_exec(1'b1, CLASS_ALU, 1'b1, 5'd2);
        alu_result_i = 32'h22222222;
        pipeline_flush_i = 1'b1;
        #1 chk("flush_idle_padv", padv_wb_o, 0);
        cyc();
        pipeline_flush_i = 1'b0; exec_valid_i = 1'b0;
        #1 chk("flush_idle_rf_wb", wb_rf_wb_o, 0);
        chk("flush_idle_result", wb_result_o, 32'h000000AA);

        // Reset while waiting on the LSU
        set_exec(1'b1, CLASS_ALU, 1'b1, 5'd13);
        alu_result_i = 32'h00001313;
        push(5'd13, 1'b1, 32'h00001313);
        cyc();
        set_exec(1'b1, CLASS_LOAD, 1'b1, 5'd12);
        lsu_size_i = SIZE_WORD;
        cyc();
        #1 chk("rstw_busy", exec_busy_o, 1);
        rst = 1'b1;
        #1 chk("rstw_rf_wb", wb_rf_wb_o, 0);
        chk("rstw_result", wb_result_o, 0);
        chk("rstw_adr", wb_rfd_adr_o, 0);
        chk("rstw_strobe", wb_new_result_o, 0);
        cyc();
        rst = 1'b0; exec_valid_i = 1'b0;
        lsu_valid_i = 1'b1; lsu_result_i = 32'h00000077;
        #1 chk("rstw_pulse_padv", padv_wb_o, 0);
        cyc();
        lsu_valid_i = 1'b0;
        #1 chk("rstw_no_strobe", wb_new_result_o, 0);
        chk("rstw_result_after", wb_result_o, 0);

        // Class NONE keeps the previous result and writes no GPR
        set_exec(1'b1, CLASS_ALU, 1'b1, 5'd4);
        alu_result_i = 32'h55AA55AA;
        push(5'd4, 1'b1, 32'h55AA55AA);
        cyc();
        set_exec(1'b1, CLASS_NONE, 1'b1, 5'd7);
        alu_result_i = 32'hFFFF0000;
        #1 chk("none_padv", padv_wb_o, 1);
        chk("none_busy", exec_busy_o, 0);
        push(5'd7, 1'b0, 32'h55AA55AA);
        cyc();
        exec_valid_i = 1'b0;
        #1 chk("none_rf_wb", wb_rf_wb_o, 0);
        chk("none_result", wb_result_o, 32'h55AA55AA);
        chk("none_adr", wb_rfd_adr_o, 7);
        cyc();
        chk("none_strobe_once", wb_new_result_o, 0);

        cyc();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mor1kx_wb_latte.md
# mor1kx_wb_latte

Writeback stage for the latte pipeline. It collects the EXECUTE result from the single-cycle ALU, the LSU or the multi-cycle multiplier. It holds the instruction in EXECUTE until the selected unit responds, then registers the destination address, write enable and result into the WB stage. Its outputs drive the register-file write port and the WB-to-DECODE/EXECUTE bypass network, including the 1-clock new-result strobe.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, datapath width
- OPTION_RF_ADDR_WIDTH, 5, GPR address width

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- pipeline_flush_i  in  1  exception/rfe flush
- exec_valid_i  in  1  EXECUTE holds an instruction
- exec_class_i  in  2  result source: 0 ALU, 1 LOAD, 2 MUL, 3 NONE (store/branch, no unit result)
- exec_rf_wb_i  in  1  instruction writes a GPR
- exec_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  destination GPR
- alu_result_i  in  OPTION_OPERAND_WIDTH  ALU result
- lsu_valid_i  in  1  LSU data/ack valid (1-cycle pulse)
- lsu_result_i  in  OPTION_OPERAND_WIDTH  raw load word
- lsu_byte_off_i  in  2  address[1:0] of the load
- lsu_size_i  in  2  0 byte, 1 half, 2 word
- lsu_zext_i  in  1  1 zero-extend, 0 sign-extend
- mul_valid_i  in  1  multiplier result valid (1-cycle pulse)
- mul_result_i  in  OPTION_OPERAND_WIDTH  multiplier result
- exec_busy_o  out  1  EXECUTE must not advance
- padv_wb_o  out  1  instruction leaves EXECUTE this cycle
- wb_new_result_o  out  1  1-clock strobe, padv_wb_o delayed by 1
- wb_rf_wb_o  out  1  WB instruction writes a GPR
- wb_rfd_adr_o  out  OPTION_RF_ADDR_WIDTH  WB destination
- wb_result_o  out  OPTION_OPERAND_WIDTH  WB result

## Operation
- FSM states: IDLE, WAIT_LSU, WAIT_MUL.
- IDLE, exec_valid_i:
  - Class ALU or NONE: padv_wb_o=1 that cycle.
  - Class LOAD with lsu_valid_i=1: padv_wb_o=1, no state change.
  - Class LOAD with lsu_valid_i=0: go to WAIT_LSU.
  - Class MUL: same rules using mul_valid_i, going to WAIT_MUL.
- WAIT_LSU/WAIT_MUL: stay until the unit's valid arrives. That cycle padv_wb_o=1, and the next state is IDLE.
- exec_busy_o = exec_valid_i & ~padv_wb_o (combinational).
- On padv_wb_o the WB registers capture, at the next edge:
  - wb_rfd_adr_o ← exec_rfd_adr_i
  - wb_rf_wb_o ← exec_rf_wb_i
  - wb_result_o ← selected unit data (load data passes through the extension path)
- The ALU result is captured in the same cycle, so alu_result_i must be valid whenever exec_valid_i is high in IDLE.
- Class NONE: wb_rf_wb_o ← 0; wb_result_o holds its previous value.
- WB registers hold between advances. wb_rf_wb_o stays asserted, because downstream hazard detection compares it every cycle.
- pipeline_flush_i (highest priority):
  - State returns to IDLE.
  - padv_wb_o is forced to 0.
  - wb_rf_wb_o ← 0 and wb_new_result_o ← 0 at the next edge.
  - wb_result_o and wb_rfd_adr_o hold their values.
  - A unit valid arriving in the flush cycle is dropped.
- Unit valid pulses arriving while not waiting on that unit are ignored.

## Timing
- Reset values (asynchronous): state IDLE, wb_rf_wb_o=0, wb_new_result_o=0, wb_rfd_adr_o=0, wb_result_o=0.
- While idle after reset, exec_busy_o=0 and padv_wb_o=0.
- Latency: ALU result appears on wb_result_o 1 cycle after acceptance. A load or multiply appears 1 cycle after its valid pulse.
- wb_new_result_o is high for exactly one cycle per advance. Back-to-back ALU instructions give consecutive strobes.
- Reset mid-wait: state is abandoned; the pending unit pulse is ignored after reset.

## Configuration
- MOR1KX_LATTE_WB_LOAD_EXT_EN defined: load data is aligned and extended in WB, big-endian.
  - Byte: offset 0 selects bits [31:24], offset 3 selects [7:0].
  - Half: offset[1]=0 selects [31:16], offset[1]=1 selects [15:0].
  - Word: data passes through.
  - Extension is zero or sign per lsu_zext_i.
  - Size 3 is treated as word.
- Undefined: lsu_result_i is written unchanged. lsu_byte_off_i, lsu_size_i and lsu_zext_i are ignored, and the LSU must deliver final data.

## Structure
- The shared defines header holds:
  - result-class encodings (ALU/LOAD/MUL/NONE)
  - load-size encodings
  - FSM state encodings
- One sub-module, mor1kx_load_ext_latte: purely combinational align/extend, instantiated only under MOR1KX_LATTE_WB_LOAD_EXT_EN.

## Test plan
- ALU, rd=5, alu_result_i=0x12345678: padv_wb_o=1 the same cycle. Next cycle: wb_rfd_adr_o=5, wb_rf_wb_o=1, wb_result_o=0x12345678, wb_new_result_o pulses once.
- LOAD, lsu_valid_i 3 cycles late: exec_busy_o=1 for 3 cycles. Then wb_result_o is the load data, with one strobe.
- With the macro, byte load, sign-extend, offset 1, data 0x11F03344: wb_result_o=0xFFFFFFF0. Same with zero-extend: 0x000000F0. Half load, offset 2, data 0x1234ABCD, sign-extend: 0xFFFFABCD.
- MUL waiting, flush asserted, mul_valid_i in the flush cycle:
  - state → IDLE, no strobe, wb_rf_wb_o=0
  - wb_result_o unchanged
- Reset asserted in WAIT_LSU, then lsu_valid_i pulses: all outputs stay at reset values and no advance occurs.
- Class NONE, rd=7: one strobe, wb_rf_wb_o=0, wb_result_o unchanged.
